// File: rtl/fault_response_controller.sv
`default_nettype none
// ============================================================================
// Module      : fault_response_controller
// Description : Sequences CPU recovery from classified faults: flush + retry
//               for minor faults, latched safe/halt for critical ones.
// Revision    : 1.0 - initial release
// ============================================================================
module fault_response_controller #(
    parameter int FLUSH_CYCLES = 2,
    parameter int MAX_RETRIES  = 3,
    parameter int CLEAN_WINDOW = 16,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       fault_type,
    input  logic             retry_ack_i,
    input  logic             clear_i,
    output logic             flush_o,
    output logic             retry_req_o,
    output logic             stall_o,
    output logic             safe_mode_o,
    output logic             halt_o,
    output logic             irq_o,
    output logic [3:0]       retry_count_o,
    output logic [CNT_W-1:0] minor_cnt_o,
    output logic [CNT_W-1:0] crit_cnt_o
);

    localparam logic [1:0]       c_st_idle   = 2'd0;
    localparam logic [1:0]       c_st_flush  = 2'd1;
    localparam logic [1:0]       c_st_retry  = 2'd2;
    localparam logic [1:0]       c_st_safe   = 2'd3;
    localparam logic [3:0]       c_flush_init = 4'(FLUSH_CYCLES);
    localparam logic [3:0]       c_max_retry  = 4'(MAX_RETRIES);
    localparam logic [7:0]       c_clean_win  = 8'(CLEAN_WINDOW);
    localparam logic [CNT_W-1:0] c_cnt_max    = '1;

    logic [1:0]       r_state;
    logic [3:0]       r_flush_cnt;
    logic [3:0]       r_retry_cnt;
    logic [7:0]       r_clean_cnt;
    logic [CNT_W-1:0] r_minor_cnt;
    logic [CNT_W-1:0] r_crit_cnt;
    logic             r_flush;
    logic             r_retry_req;
    logic             r_stall;
    logic             r_safe;
    logic             r_halt;
    logic             r_irq;

    logic [1:0]       w_state_nxt;
    logic [3:0]       w_flush_nxt;
    logic [3:0]       w_retry_nxt;
    logic [7:0]       w_clean_nxt;
    logic             w_minor_inc;
    logic             w_crit_inc;
    logic             w_is_crit;

    assign w_is_crit = fault_type[1];

    always_comb begin
        w_state_nxt = r_state;
        w_flush_nxt = r_flush_cnt;
        w_retry_nxt = r_retry_cnt;
        w_clean_nxt = r_clean_cnt;
        w_minor_inc = 1'b0;
        w_crit_inc  = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (fault_type == 2'b00) begin
                    if (r_clean_cnt < c_clean_win) w_clean_nxt = r_clean_cnt + 8'd1;
                    if (w_clean_nxt == c_clean_win) w_retry_nxt = 4'd0;
                end else if (fault_type == 2'b01) begin
                    w_minor_inc = 1'b1;
                    w_clean_nxt = 8'd0;
                    // Retry budget exhausted: the minor fault is treated as critical
                    if (r_retry_cnt == c_max_retry) begin
                        w_crit_inc  = 1'b1;
                        w_state_nxt = c_st_safe;
                    end else begin
                        w_retry_nxt = r_retry_cnt + 4'd1;
                        w_flush_nxt = c_flush_init;
                        w_state_nxt = c_st_flush;
                    end
                end else begin
                    w_crit_inc  = 1'b1;
                    w_state_nxt = c_st_safe;
                end
            end
            c_st_flush: begin
                if (w_is_crit) begin
                    w_crit_inc  = 1'b1;
                    w_state_nxt = c_st_safe;
                end else begin
                    w_flush_nxt = r_flush_cnt - 4'd1;
                    if (r_flush_cnt <= 4'd1) w_state_nxt = c_st_retry;
                end
            end
            c_st_retry: begin
                if (w_is_crit) begin
                    w_crit_inc  = 1'b1;
                    w_state_nxt = c_st_safe;
                end else if (retry_ack_i) begin
                    w_state_nxt = c_st_idle;
                end
            end
            c_st_safe: begin
                // Clear has priority over any fault presented alongside it
                if (clear_i) begin
                    w_state_nxt = c_st_idle;
                    w_retry_nxt = 4'd0;
                    w_clean_nxt = 8'd0;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_flush_cnt <= 4'd0;
            r_retry_cnt <= 4'd0;
            r_clean_cnt <= 8'd0;
            r_minor_cnt <= '0;
            r_crit_cnt  <= '0;
            r_flush     <= 1'b0;
            r_retry_req <= 1'b0;
            r_stall     <= 1'b0;
            r_safe      <= 1'b0;
            r_halt      <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_nxt;
            r_retry_cnt <= w_retry_nxt;
            r_clean_cnt <= w_clean_nxt;
            if (w_minor_inc && (r_minor_cnt != c_cnt_max)) r_minor_cnt <= r_minor_cnt + 1'b1;
            if (w_crit_inc && (r_crit_cnt != c_cnt_max))   r_crit_cnt  <= r_crit_cnt + 1'b1;
            r_flush     <= (w_state_nxt == c_st_flush);
            r_retry_req <= (w_state_nxt == c_st_retry);
            r_stall     <= (w_state_nxt != c_st_idle);
            r_safe      <= (w_state_nxt == c_st_safe);
            r_halt      <= (w_state_nxt == c_st_safe);
            r_irq       <= (w_state_nxt == c_st_safe) && (r_state != c_st_safe);
        end
    end

    assign flush_o       = r_flush;
    assign retry_req_o   = r_retry_req;
    assign stall_o       = r_stall;
    assign safe_mode_o   = r_safe;
    assign halt_o        = r_halt;
    assign irq_o         = r_irq;
    assign retry_count_o = r_retry_cnt;
    assign minor_cnt_o   = r_minor_cnt;
    assign crit_cnt_o    = r_crit_cnt;

endmodule
`default_nettype wire
